// File: rtl/shift_sweep_ctrl_if.sv
// Signal bundle between a sweep host/shifter environment and shift_sweep_ctrl.
// SHIFT_SWEEP_BACKPRESSURE_EN adds res_ready for result handshaking.
interface shift_sweep_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int AMT_W  = 3
);
   logic              start;
   logic [DATA_W-1:0] din;
   logic [AMT_W-1:0]  amt_first;
   logic [AMT_W-1:0]  amt_last;
   logic [DATA_W-1:0] sh_a;
   logic [AMT_W-1:0]  sh_amt;
   logic [DATA_W-1:0] sh_y;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic [AMT_W-1:0]  res_amt;
   logic              busy;
   logic              done;
`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
   logic              res_ready;
`endif

   // Host side: issues sweeps, models the shifter, consumes results.
   modport master (
`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
      output res_ready,
`endif
      output start, din, amt_first, amt_last, sh_y,
      input  sh_a, sh_amt, res_valid, res_data, res_amt, busy, done
   );

   // Controller side.
   modport slave (
`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
      input  res_ready,
`endif
      input  start, din, amt_first, amt_last, sh_y,
      output sh_a, sh_amt, res_valid, res_data, res_amt, busy, done
   );
endinterface

// File: rtl/shift_sweep_ctrl.sv
// Sweeps a latched word through a range of shift amounts on an external shifter,
// capturing one result per amount. Optional macro: SHIFT_SWEEP_BACKPRESSURE_EN.
module shift_sweep_ctrl #(
   parameter int DATA_W   = 8,
   parameter int AMT_W    = 3,
   parameter int HOLD_CYC = 20
) (
   input  logic             clk,
   input  logic             rst,
   shift_sweep_ctrl_if.slave bus
);

   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_CAPTURE,
      S_WAIT_ACK,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_a_q, sh_a_d;
   logic [AMT_W-1:0]  sh_amt_q, sh_amt_d;
   logic [AMT_W-1:0]  amt_last_q, amt_last_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic [AMT_W-1:0]  res_amt_q, res_amt_d;
   logic              last_step;

   assign last_step = (sh_amt_q == amt_last_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sh_a_q      <= '0;
         sh_amt_q    <= '0;
         amt_last_q  <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_amt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_a_q      <= sh_a_d;
         sh_amt_q    <= sh_amt_d;
         amt_last_q  <= amt_last_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_amt_q   <= res_amt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_a_d      = sh_a_q;
      sh_amt_d    = sh_amt_q;
      amt_last_d  = amt_last_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_amt_d   = res_amt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               sh_a_d     = bus.din;
               sh_amt_d   = bus.amt_first;
               amt_last_d = bus.amt_last;
               cnt_d      = '0;
               state_d    = S_DRIVE;
            end
         end

         S_DRIVE: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_CAPTURE: begin
            res_valid_d = 1'b1;
            res_data_d  = bus.sh_y;
            res_amt_d   = sh_amt_q;
`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
            state_d     = S_WAIT_ACK;
`else
            if (last_step) begin
               state_d = S_FINISH;
            end else begin
               sh_amt_d = sh_amt_q + AMT_ONE;
               cnt_d    = '0;
               state_d  = S_DRIVE;
            end
`endif
         end

`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
         // The amount only advances on the handshake, so a stalled sweep keeps sh_amt.
         S_WAIT_ACK: begin
            if (bus.res_ready) begin
               if (last_step) begin
                  state_d = S_FINISH;
               end else begin
                  sh_amt_d = sh_amt_q + AMT_ONE;
                  cnt_d    = '0;
                  state_d  = S_DRIVE;
               end
            end else begin
               res_valid_d = 1'b1;
            end
         end
`endif

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.sh_a      = sh_a_q;
      bus.sh_amt    = sh_amt_q;
      bus.res_valid = res_valid_q;
      bus.res_data  = res_data_q;
      bus.res_amt   = res_amt_q;
      bus.busy      = (state_q != S_IDLE);
      bus.done      = (state_q == S_FINISH);
   end

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Directed bench for shift_sweep_ctrl with HOLD_CYC=4 and a rotate-right shifter model.
// Covers SHIFT_SWEEP_BACKPRESSURE_EN when that macro is defined.
module tb_shift_sweep_ctrl;
   localparam int DATA_W = 8;
   localparam int AMT_W  = 3;
   localparam int HOLD   = 4;
`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
   localparam int PERIOD   = HOLD + 2;
   localparam int DONE_LAG = 1;
`else
   localparam int PERIOD   = HOLD + 1;
   localparam int DONE_LAG = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   always #5 clk = ~clk;

   shift_sweep_ctrl_if #(.DATA_W(DATA_W), .AMT_W(AMT_W)) bus ();

`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
   assign bus.res_ready = rdy;
`endif

   function automatic logic [7:0] ror8(input logic [7:0] a, input logic [2:0] s);
      logic [15:0] t;
      t = {a, a} >> s;
      return t[7:0];
   endfunction

   assign bus.sh_y = ror8(bus.sh_a, bus.sh_amt);

   shift_sweep_ctrl #(.DATA_W(DATA_W), .AMT_W(AMT_W), .HOLD_CYC(HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int q_amt[$];
   int q_data[$];
   int q_cyc[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int sh_a_bad = 0;
   int sweep_din = 0;
   int start_cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int exp_a[4];
   int exp_d[4];

   // Result / done logger sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.res_valid && rdy) begin
            q_amt.push_back(int'(bus.res_amt));
            q_data.push_back(int'(bus.res_data));
            q_cyc.push_back(cyc);
            $display("[%0d] result amt=%0d data=0x%02h", cyc, bus.res_amt, bus.res_data);
         end
         if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            $display("[%0d] done", cyc);
         end
         if (bus.busy && (int'(bus.sh_a) != sweep_din)) sh_a_bad = sh_a_bad + 1;
      end
   end

   task automatic check_val(input string tag, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act != exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      else n_pass = n_pass + 1;
   endtask

   task automatic clear_log(input int d);
      q_amt.delete();
      q_data.delete();
      q_cyc.delete();
      done_cnt  = 0;
      sh_a_bad  = 0;
      sweep_din = d;
   endtask

   task automatic start_sweep(input logic [7:0] d, input logic [2:0] f, input logic [2:0] l);
      clear_log(int'(d));
      bus.din       = d;
      bus.amt_first = f;
      bus.amt_last  = l;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b0;
      $display("[%0d] sweep din=0x%02h first=%0d last=%0d", cyc, d, f, l);
   endtask

   task automatic wait_done(input string tag, input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val({tag, "_done_seen"}, int'(done_cnt >= target), 1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic chk_sweep(input string tag, input int n);
      check_val({tag, "_count"}, q_data.size(), n);
      for (int i = 0; i < n && i < q_data.size(); i++) begin
         check_val($sformatf("%s_amt%0d", tag, i), q_amt[i], exp_a[i]);
         check_val($sformatf("%s_data%0d", tag, i), q_data[i], exp_d[i]);
      end
      if (q_cyc.size() > 0) check_val({tag, "_latency"}, q_cyc[0] - start_cyc, HOLD + 1);
      for (int i = 1; i < q_cyc.size(); i++)
         check_val($sformatf("%s_period%0d", tag, i), q_cyc[i] - q_cyc[i-1], PERIOD);
      check_val({tag, "_done_cnt"}, done_cnt, 1);
      if (q_cyc.size() == n) check_val({tag, "_done_cyc"}, done_cyc - q_cyc[n-1], DONE_LAG);
      check_val({tag, "_sh_a_stable"}, sh_a_bad, 0);
      check_val({tag, "_idle"}, int'(bus.busy), 0);
   endtask

   task automatic chk_zero(input string tag);
      check_val({tag, "_sh_a"}, int'(bus.sh_a), 0);
      check_val({tag, "_sh_amt"}, int'(bus.sh_amt), 0);
      check_val({tag, "_res_valid"}, int'(bus.res_valid), 0);
      check_val({tag, "_res_data"}, int'(bus.res_data), 0);
      check_val({tag, "_res_amt"}, int'(bus.res_amt), 0);
      check_val({tag, "_busy"}, int'(bus.busy), 0);
      check_val({tag, "_done"}, int'(bus.done), 0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.din       = '0;
      bus.amt_first = '0;
      bus.amt_last  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: basic sweep 1..4
      start_sweep(8'h0F, 3'd1, 3'd4);
      wait_done("s1", 1);
      exp_a = '{1, 2, 3, 4};
      exp_d = '{8'h87, 8'hC3, 8'hE1, 8'hF0};
      chk_sweep("s1", 4);

      // 2: wrapping amounts 6,7,0,1
      start_sweep(8'h01, 3'd6, 3'd1);
      wait_done("s2", 1);
      exp_a = '{6, 7, 0, 1};
      exp_d = '{8'h04, 8'h02, 8'h01, 8'h80};
      chk_sweep("s2", 4);

      // 3: single step
      start_sweep(8'hA5, 3'd3, 3'd3);
      wait_done("s3", 1);
      exp_a = '{3, 0, 0, 0};
      exp_d = '{8'hB4, 0, 0, 0};
      chk_sweep("s3", 1);

      // 4: start and input changes while busy are ignored
      start_sweep(8'h0F, 3'd1, 3'd4);
      repeat (7) @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.din       = 8'hFF;
      bus.amt_first = 3'd0;
      bus.amt_last  = 3'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.din   = 8'h33;
      wait_done("s4", 1);
      exp_a = '{1, 2, 3, 4};
      exp_d = '{8'h87, 8'hC3, 8'hE1, 8'hF0};
      chk_sweep("s4", 4);

      // 5: reset during step 2, then a normal sweep
      start_sweep(8'h0F, 3'd1, 3'd4);
      repeat (7) @(posedge clk);
      #1;
      check_val("s5_pre_amt", int'(bus.sh_amt), 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("s5_rst");
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check_val("s5_results", q_data.size(), 1);
      check_val("s5_no_done", done_cnt, 0);
      check_val("s5_idle", int'(bus.busy), 0);
      start_sweep(8'hA5, 3'd3, 3'd3);
      wait_done("s5b", 1);
      exp_a = '{3, 0, 0, 0};
      exp_d = '{8'hB4, 0, 0, 0};
      chk_sweep("s5b", 1);

      // start held high: back-to-back single-step sweeps
      clear_log(8'hA5);
      bus.din       = 8'hA5;
      bus.amt_first = 3'd3;
      bus.amt_last  = 3'd3;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      begin
         int n;
         n = 0;
         while (done_cnt < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_val("held_count", q_data.size(), 2);
      check_val("held_done_cnt", done_cnt, 2);
      if (q_cyc.size() == 2) begin
         check_val("held_latency", q_cyc[0] - start_cyc, HOLD + 1);
         check_val("held_gap", q_cyc[1] - q_cyc[0], PERIOD + 2);
         check_val("held_data1", q_data[1], 8'hB4);
      end

`ifdef SHIFT_SWEEP_BACKPRESSURE_EN
      // 6: stall on step 1 for 7 cycles
      rdy = 1'b0;
      start_sweep(8'h0F, 3'd1, 3'd4);
      repeat (5) @(posedge clk);
      #1;
      check_val("s6_valid_first", int'(bus.res_valid), 1);
      check_val("s6_data_first", int'(bus.res_data), 8'h87);
      repeat (6) @(posedge clk);
      #1;
      check_val("s6_valid_held", int'(bus.res_valid), 1);
      check_val("s6_data_held", int'(bus.res_data), 8'h87);
      check_val("s6_amt_held", int'(bus.sh_amt), 1);
      check_val("s6_no_done", done_cnt, 0);
      rdy = 1'b1;
      wait_done("s6", 1);
      check_val("s6_count", q_data.size(), 4);
      if (q_data.size() == 4) begin
         check_val("s6_amt0", q_amt[0], 1);
         check_val("s6_data0", q_data[0], 8'h87);
         check_val("s6_data3", q_data[3], 8'hF0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
